// File: rtl/byte_serial_add_sequencer_pkg.sv
// rtl/byte_serial_add_sequencer_pkg.sv - shared FSM encoding and slice width for the byte-serial adder
package byte_serial_add_sequencer_pkg;

   localparam int BYTE = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/byte_serial_add_sequencer_eight_bit_adder.sv
// rtl/byte_serial_add_sequencer_eight_bit_adder.sv - the single 8-bit adder slice shared by all passes
module byte_serial_add_sequencer_eight_bit_adder
   import byte_serial_add_sequencer_pkg::*;
(
   input  logic [BYTE-1:0] x,
   input  logic [BYTE-1:0] y,
   input  logic            cy_in,
   output logic [BYTE-1:0] s,
   output logic            cy8
);

   logic [BYTE:0] sum;

   always_comb begin
      sum = {1'b0, x} + {1'b0, y} + {{BYTE{1'b0}}, cy_in};
      s   = sum[BYTE-1:0];
      cy8 = sum[BYTE];
   end

endmodule

// File: rtl/byte_serial_add_sequencer.sv
// rtl/byte_serial_add_sequencer.sv - WIDTH-bit add/sub sequenced one byte per cycle through one slice
module byte_serial_add_sequencer
   import byte_serial_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int NBYTES = WIDTH / BYTE;
   localparam int IDX_W  = $clog2(NBYTES);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic               a_sign_q, a_sign_d;
   logic               b_sign_q, b_sign_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;

   logic [BYTE-1:0]    slice_x, slice_y, slice_s;
   logic               slice_cy8;
   logic               accept;
   logic               last_pass;

   always_comb begin
      accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
      last_pass = (idx_q == IDX_W'(NBYTES - 1));
   end

   // Byte mux feeding the shared slice from the current pass index.
   always_comb begin
      slice_x = '0;
      slice_y = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            slice_x = a_q[i*BYTE +: BYTE];
            slice_y = b_q[i*BYTE +: BYTE];
         end
      end
   end

   byte_serial_add_sequencer_eight_bit_adder u_slice (
      .x     (slice_x),
      .y     (slice_y),
      .cy_in (carry_q),
      .s     (slice_s),
      .cy8   (slice_cy8)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)     state_d = ST_RUN;
         ST_RUN:  if (last_pass) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
      done  = (state_q == ST_DONE);
   end

   // Subtraction is folded in at accept time: B' = ~b and carry-in = 1.
   always_comb begin
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      a_sign_d = a_sign_q;
      b_sign_d = b_sign_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      if (accept) begin
         a_d      = a;
         b_d      = sub ? ~b : b;
         carry_d  = sub;
         a_sign_d = a[WIDTH-1];
         b_sign_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
         idx_d    = '0;
      end else if (state_q == ST_RUN) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
               result_d[i*BYTE +: BYTE] = slice_s;
            end
         end
         carry_d = slice_cy8;
         if (last_pass) begin
            idx_d  = '0;
            cout_d = slice_cy8;
            zero_d = ~|result_d;
            ovf_d  = (a_sign_q == b_sign_q) && (result_d[WIDTH-1] != a_sign_q);
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         a_sign_q <= a_sign_d;
         b_sign_q <= b_sign_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      result   = result_q;
      cout     = cout_q;
      overflow = ovf_q;
      zero     = zero_q;
   end

endmodule

// File: tb/tb_byte_serial_add_sequencer.sv
// tb/tb_byte_serial_add_sequencer.sv - directed and random checks of the byte-serial adder
module tb_byte_serial_add_sequencer;

   localparam int WIDTH  = 32;
   localparam int NBYTES = WIDTH / 8;

   logic             clk = 1'b0;
   logic             rst, start, sub;
   logic [WIDTH-1:0] a, b;
   logic             ready, done, cout, overflow, zero;
   logic [WIDTH-1:0] result;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] last_res;

   byte_serial_add_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .ready(ready), .done(done), .result(result), .cout(cout),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference from signed/unsigned integer arithmetic on the operands.
   task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic msub,
                        output logic [WIDTH-1:0] r, output logic c, output logic v, output logic z);
      longint sa, sb, sr;
      logic [63:0] u;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (msub) begin
         r  = ma - mb;
         c  = (ma >= mb);
         sr = sa - sb;
      end else begin
         u  = {32'b0, ma} + {32'b0, mb};
         r  = u[WIDTH-1:0];
         c  = (u >= 64'h1_0000_0000);
         sr = sa + sb;
      end
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (r == '0);
   endtask

   // Issues an op from a ready cycle and returns in the done cycle.
   task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic osub,
                         input bit hold_start);
      logic [WIDTH-1:0] er;
      logic ec, ev, ez;
      int edges;
      model(oa, ob, osub, er, ec, ev, ez);
      check("ready_before_start", {31'b0, ready}, 32'd1);
      a = oa; b = ob; sub = osub; start = 1'b1;
      step();
      start = hold_start;
      edges = 0;
      while (!done && edges < 20) begin
         check("ready_in_run", {31'b0, ready}, 32'd0);
         if (hold_start) begin
            a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
         end
         step();
         edges++;
      end
      start = 1'b0;
      check("latency", edges, NBYTES);
      check("result", result, er);
      check("cout", {31'b0, cout}, {31'b0, ec});
      check("overflow", {31'b0, overflow}, {31'b0, ev});
      check("zero", {31'b0, zero}, {31'b0, ez});
      last_res = er;
   endtask

   task automatic idle_check();
      step();
      check("done_pulse_width", {31'b0, done}, 32'd0);
      check("ready_idle", {31'b0, ready}, 32'd1);
      check("result_held", result, last_res);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; last_res = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_cout", {31'b0, cout}, 32'd0);
      check("rst_overflow", {31'b0, overflow}, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd1);

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      idle_check();
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      idle_check();
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      idle_check();
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      idle_check();
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
      idle_check();
      run_op(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
      run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
      idle_check();

      // Reset in the second RUN cycle aborts the op without a done pulse.
      a = 32'hDEAD_BEEF; b = 32'h0102_0304; sub = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ready", {31'b0, ready}, 32'd1);
      check("abort_result", result, 32'd0);
      check("abort_zero", {31'b0, zero}, 32'd1);
      for (int i = 0; i < NBYTES + 2; i++) begin
         check("abort_no_done", {31'b0, done}, 32'd0);
         step();
      end
      last_res = '0;
      run_op(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
      idle_check();

      for (int n = 0; n < 24; n++) begin
         logic [WIDTH-1:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (n % 6 == 1) rb = ~ra;
         if (n % 6 == 3) rb = ra;
         run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_check();
      end
      idle_check();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
